// File: rtl/bin_to_7seg_scan.sv
// Binary to BCD converter (sequential double-dabble) with a multiplexed
// 7-segment scan driver, leading-zero blanking and overflow dashes.
module bin_to_7seg_scan #(
    parameter int unsigned BIN_W    = 14,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned LZ_BLANK = 1
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [BIN_W-1:0]      BIN,
    input  logic                  LOAD,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVF,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [6:0]            SEG7OUT,
    output logic [DIGITS-1:0]     SEG7COM
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned PRE_W = $clog2(PRESCALE);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Conversion state
    state_t             state_q, state_d;
    logic [BIN_W-1:0]   sreg_q, sreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;

    // Scan state
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  com_q, com_d;

    // Datapath intermediates
    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W-1:0]   scratch_sh;
    logic [BIN_W-1:0]   sreg_sh;
    logic               shift_out;
    logic [3:0]         digit_val;
    logic               digit_blank;
    logic               zero_run;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD code
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // One double-dabble step: add-3 correction, then shift {scratch, sreg} left
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        {shift_out, scratch_sh, sreg_sh} = {scratch_adj, sreg_q, 1'b0};
    end

    // Conversion FSM next state; BCD/OVF/DONE are loaded on the edge entering
    // FINISH so the FINISH cycle itself is the DONE cycle and can accept LOAD
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        scratch_d = scratch_q;
        ovf_acc_d = ovf_acc_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (LOAD) begin
                    sreg_d    = BIN;
                    scratch_d = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sreg_d    = sreg_sh;
                scratch_d = scratch_sh;
                ovf_acc_d = ovf_acc_q | shift_out;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scratch_sh;
                    ovf_d   = ovf_acc_q | shift_out;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scan prescaler and digit index advance
    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_W'(PRESCALE - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Pick the digit about to be shown and decide whether it is a leading zero
    always_comb begin
        digit_val   = 4'd0;
        digit_blank = 1'b0;
        zero_run    = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run & (bcd_q[4*i +: 4] == 4'd0);
            if (idx_d == IDX_W'(i)) begin
                digit_val   = bcd_q[4*i +: 4];
                digit_blank = (LZ_BLANK != 0) && (i != 0) && zero_run;
            end
        end
    end

    // Segment and common drive for the next index, so both change together
    always_comb begin
        com_d = ~(DIGITS'(1) << idx_d);
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (digit_blank) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(digit_val);
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            scratch_q <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            presc_q   <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_ZERO;
            com_q     <= ~DIGITS'(1);
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            scratch_q <= scratch_d;
            ovf_acc_q <= ovf_acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            com_q     <= com_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign OVF     = ovf_q;
    assign BCD     = bcd_q;
    assign SEG7OUT = seg_q;
    assign SEG7COM = com_q;

endmodule
